// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, named register addresses and address range helper for the register file
package regfile_pkg;
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_NUM_REGS = 8;
  typedef logic [2:0] reg_addr_t;
  localparam reg_addr_t R0 = 3'b000;
  localparam reg_addr_t R1 = 3'b001;
  localparam reg_addr_t R2 = 3'b010;
  localparam reg_addr_t R3 = 3'b011;
  localparam reg_addr_t R4 = 3'b100;
  localparam reg_addr_t R5 = 3'b101;
  localparam reg_addr_t R6 = 3'b110;
  localparam reg_addr_t R7 = 3'b111;
  function automatic logic addr_ok(int unsigned addr, int unsigned n);
    return addr < n;
  endfunction
endpackage

// File: rtl/regfile_if.sv
// regfile_if: write port plus two read ports of the register file, master drives addresses and write data
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] ra_addr;
  logic [DATA_W-1:0] ra_data;
  logic              ra_valid;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;
  logic              rb_valid;
  modport master (
    output w_en, w_addr, w_data, ra_addr, rb_addr,
    input  ra_data, ra_valid, rb_data, rb_valid
  );
  modport slave (
    input  w_en, w_addr, w_data, ra_addr, rb_addr,
    output ra_data, ra_valid, rb_data, rb_valid
  );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: combinational read mux with range check and valid select.
// REGFILE_BYPASS_EN adds same-cycle write-through from the write port.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                             rst_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
  input  logic [NUM_REGS-1:0]              valid_i,
  input  logic [ADDR_W-1:0]                addr_i,
  input  logic                             w_en_i,
  input  logic [ADDR_W-1:0]                w_addr_i,
  input  logic [DATA_W-1:0]                w_data_i,
  output logic [DATA_W-1:0]                data_o,
  output logic                             valid_o
);
  logic in_range;
  assign in_range = addr_ok(32'(addr_i), NUM_REGS);
`ifdef REGFILE_BYPASS_EN
  logic hit;
  assign hit = !rst_i && w_en_i && (w_addr_i == addr_i) && in_range;
  assign data_o = hit ? w_data_i : in_range ? regs_i[addr_i] : '0;
  assign valid_o = hit || (in_range && valid_i[addr_i]);
`else
  logic unused_bypass;
  assign unused_bypass = ^{rst_i, w_en_i, w_addr_i, w_data_i};
  assign data_o = in_range ? regs_i[addr_i] : '0;
  assign valid_o = in_range && valid_i[addr_i];
`endif
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NUM_REGS x DATA_W register file, one sync write port, two async read ports with valid flags.
// Optional REGFILE_BYPASS_EN forwards the in-flight write to matching read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             valid_q, valid_d;
  logic                            wr;
  // out-of-range writes are dropped here so they never touch state
  assign wr = bus.w_en && addr_ok(32'(bus.w_addr), NUM_REGS);
  always_comb begin
    regs_d = regs_q;
    valid_d = valid_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (wr && 32'(bus.w_addr) == i) ? bus.w_data : regs_q[i];
      valid_d[i] = (wr && 32'(bus.w_addr) == i) || valid_q[i];
    end
  end
  always_ff @(posedge clk) begin
    regs_q <= rst ? {NUM_REGS{RESET_VAL}} : regs_d;
    valid_q <= rst ? '0 : valid_d;
  end
  regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_port_a (
    .rst_i    (rst),
    .regs_i   (regs_q),
    .valid_i  (valid_q),
    .addr_i   (bus.ra_addr),
    .w_en_i   (bus.w_en),
    .w_addr_i (bus.w_addr),
    .w_data_i (bus.w_data),
    .data_o   (bus.ra_data),
    .valid_o  (bus.ra_valid)
  );
  regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_port_b (
    .rst_i    (rst),
    .regs_i   (regs_q),
    .valid_i  (valid_q),
    .addr_i   (bus.rb_addr),
    .w_en_i   (bus.w_en),
    .w_addr_i (bus.w_addr),
    .w_data_i (bus.w_data),
    .data_o   (bus.rb_data),
    .valid_o  (bus.rb_valid)
  );
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: drives an 8-register and a 6-register instance with identical stimulus
// and checks all four read ports against an array-based reference model.
module tb_regfile_2r1w;
  import regfile_pkg::*;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  regfile_if #(.DATA_W(16), .NUM_REGS(8)) b8 ();
  regfile_if #(.DATA_W(16), .NUM_REGS(6)) b6 ();
  regfile_2r1w #(.DATA_W(16), .NUM_REGS(8), .RESET_VAL(16'h0000)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  regfile_2r1w #(.DATA_W(16), .NUM_REGS(6), .RESET_VAL(16'h0000)) dut6 (.clk(clk), .rst(rst), .bus(b6));
  always #5 clk = ~clk;
  logic [15:0] md8 [8];
  bit          mv8 [8];
  logic [15:0] md6 [6];
  bit          mv6 [6];
  task automatic set(input bit r, input bit en, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [2:0] aa, input logic [2:0] ab);
    rst = r;
    b8.w_en = en; b8.w_addr = wa; b8.w_data = wd; b8.ra_addr = aa; b8.rb_addr = ab;
    b6.w_en = en; b6.w_addr = wa; b6.w_data = wd; b6.ra_addr = aa; b6.rb_addr = ab;
    #1;
  endtask
  task automatic tick();
    bit r = rst;
    bit en = b8.w_en;
    int wa = int'(b8.w_addr);
    logic [15:0] wd = b8.w_data;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 8; i++) begin md8[i] = 16'h0; mv8[i] = 0; end
      for (int i = 0; i < 6; i++) begin md6[i] = 16'h0; mv6[i] = 0; end
    end else if (en) begin
      md8[wa] = wd; mv8[wa] = 1;
      if (wa < 6) begin md6[wa] = wd; mv6[wa] = 1; end
    end
  endtask
  function automatic logic [16:0] exp8(input logic [2:0] a);
    if (BYP && !rst && b8.w_en && b8.w_addr == a) return {1'b1, b8.w_data};
    return {mv8[a], md8[a]};
  endfunction
  function automatic logic [16:0] exp6(input logic [2:0] a);
    if (a >= 3'd6) return 17'h0;
    if (BYP && !rst && b6.w_en && b6.w_addr == a) return {1'b1, b6.w_data};
    return {mv6[a], md6[a]};
  endfunction
  function automatic logic [67:0] expect_all();
    return {exp8(b8.ra_addr), exp8(b8.rb_addr), exp6(b6.ra_addr), exp6(b6.rb_addr)};
  endfunction
  function automatic logic [67:0] obs();
    return {b8.ra_valid, b8.ra_data, b8.rb_valid, b8.rb_data,
            b6.ra_valid, b6.ra_data, b6.rb_valid, b6.rb_data};
  endfunction
  task automatic test_reset();
    set(1, 1, 3'($urandom), 16'($urandom), 0, 0);
    tick();
    for (int a = 0; a < 8; a++) begin
      set(0, 0, 0, 0, 3'(a), 3'(7 - a));
      checks++;
      if (obs() !== expect_all() || b8.ra_valid !== 1'b0 || b8.ra_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset addr=%0d got %h expected %h", a, obs(), expect_all());
      end
    end
  endtask
  task automatic test_write_pattern();
    for (int i = 0; i < 8; i++) begin
      set(0, 1, 3'(i), 16'h0001 << i, 0, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      set(0, 0, 0, 0, 3'(i), 3'(7 - i));
      checks++;
      if (obs() !== expect_all() || b8.ra_data !== (16'h0001 << i) || b8.rb_data !== (16'h0001 << (7 - i))) begin
        errors++;
        $display("FAIL write_pattern i=%0d got %h expected %h", i, obs(), expect_all());
      end
    end
  endtask
  task automatic test_hold();
    for (int i = 0; i < 8; i++) begin
      set(0, 0, 3'(i), 16'hFFFF, 3'(i), 3'(7 - i));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      set(0, 0, 0, 16'hFFFF, 3'(i), 3'(7 - i));
      checks++;
      if (obs() !== expect_all() || b8.ra_data !== (16'h0001 << i)) begin
        errors++;
        $display("FAIL hold i=%0d got %h expected %h", i, obs(), expect_all());
      end
    end
  endtask
  task automatic test_bypass();
    set(0, 1, R3, 16'hBEEF, R3, R3);
    checks++;
    if (obs() !== expect_all()) begin
      errors++;
      $display("FAIL bypass_before got %h expected %h", obs(), expect_all());
    end
    tick();
    set(0, 0, 0, 0, R3, R3);
    checks++;
    if (obs() !== expect_all() || b8.ra_data !== 16'hBEEF || b8.rb_valid !== 1'b1) begin
      errors++;
      $display("FAIL bypass_after got %h expected %h", obs(), expect_all());
    end
  endtask
  task automatic test_reset_priority();
    set(1, 1, R5, 16'h1234, R5, R5);
    checks++;
    if (obs() !== expect_all()) begin
      errors++;
      $display("FAIL reset_no_bypass got %h expected %h", obs(), expect_all());
    end
    tick();
    set(0, 0, 0, 0, R5, R5);
    checks++;
    if (obs() !== expect_all() || b8.ra_valid !== 1'b0 || b8.ra_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_priority got %h expected %h", obs(), expect_all());
    end
    for (int i = 0; i < 4; i++) begin
      set(0, 1, 3'($urandom), 16'($urandom), 0, 0);
      tick();
    end
    set(1, 0, 0, 0, 0, 0);
    tick();
    for (int a = 0; a < 8; a++) begin
      set(0, 0, 0, 0, 3'(a), 3'(7 - a));
      checks++;
      if (obs() !== expect_all() || b8.ra_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset addr=%0d got %h expected %h", a, obs(), expect_all());
      end
    end
  endtask
  task automatic test_out_of_range();
    for (int i = 0; i < 6; i++) begin
      set(0, 1, 3'(i), 16'($urandom), 0, 0);
      tick();
    end
    set(0, 1, 3'd7, 16'hAAAA, 3'd7, 3'd6);
    checks++;
    if (obs() !== expect_all() || b6.ra_valid !== 1'b0 || b6.ra_data !== 16'h0000) begin
      errors++;
      $display("FAIL oor_before got %h expected %h", obs(), expect_all());
    end
    tick();
    for (int a = 0; a < 8; a++) begin
      set(0, 0, 0, 0, 3'(a), 3'(7 - a));
      checks++;
      if (obs() !== expect_all()) begin
        errors++;
        $display("FAIL oor_after addr=%0d got %h expected %h", a, obs(), expect_all());
      end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set($urandom_range(0, 31) == 0, 1'($urandom), 3'($urandom), 16'($urandom),
          3'($urandom), ($urandom_range(0, 3) == 0) ? b8.w_addr : 3'($urandom));
      checks++;
      if (obs() !== expect_all()) begin
        errors++;
        $display("FAIL random n=%0d got %h expected %h", n, obs(), expect_all());
      end
      tick();
    end
  endtask
  initial begin
    set(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_write_pattern();
    test_hold();
    test_bypass();
    test_reset_priority();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
